// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
// Turns the raw PS/2 Set-2 byte stream into single key events carrying a
// code, an extended (E0) flag and a make/break (F0) flag. It also tracks
// held flags for the MiniPaint cursor keys and the space (draw) key.
// Optional build macro: PS2_TYPEMATIC_FILTER_EN suppresses typematic
// repeats of the most recently emitted make.

module ps2_scancode_decoder #(
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic [4:0] key_held,
  output logic       protocol_err
);

  typedef enum logic [2:0] {
    IDLE,
    GOT_E0,
    GOT_F0,
    GOT_E0F0,
    SKIP_E1
  } state_t;

  localparam logic [21:0] TIMEOUT_LAST = 22'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  skipCnt_q, skipCnt_d;
  logic [21:0] idleCnt_q, idleCnt_d;

  logic        keyValid_q, keyValid_d;
  logic [7:0]  keyCode_q, keyCode_d;
  logic        keyExt_q, keyExt_d;
  logic        keyRel_q, keyRel_d;
  logic [4:0]  held_q, held_d;
  logic        protoErr_q, protoErr_d;

  logic        emitMake;
  logic        emitBreak;
  logic        emitExt;
  logic        errPulse;
  logic        suppress;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic        recValid_q, recValid_d;
  logic        recExt_q, recExt_d;
  logic [7:0]  recCode_q, recCode_d;
  logic        recMatch;
`endif

  // Held-flag bit for a given {ext, code}: bit 0 up, 1 down, 2 left,
  // 3 right, 4 space. Zero for keys that are not tracked.
  function automatic logic [4:0] heldMask(input logic ext, input logic [7:0] code);
    heldMask = 5'b00000;
    if (!ext) begin
      if (code == 8'h29) heldMask = 5'b10000;
    end else begin
      case (code)
        8'h75:   heldMask = 5'b00001;
        8'h72:   heldMask = 5'b00010;
        8'h6B:   heldMask = 5'b00100;
        8'h74:   heldMask = 5'b01000;
        default: heldMask = 5'b00000;
      endcase
    end
  endfunction

  // Prefix tracking: decides the next state and whether the current byte
  // completes a make, a break, or a malformed sequence. A byte always wins
  // over a coincident timeout because the timeout branch only runs on
  // cycles without a strobe.
  always_comb begin
    state_d   = state_q;
    skipCnt_d = skipCnt_q;
    idleCnt_d = idleCnt_q;
    emitMake  = 1'b0;
    emitBreak = 1'b0;
    emitExt   = 1'b0;
    errPulse  = 1'b0;
    if (received_data_en) begin
      idleCnt_d = '0;
      case (state_q)
        IDLE: begin
          if (received_data == 8'hE0) begin
            state_d = GOT_E0;
          end else if (received_data == 8'hF0) begin
            state_d = GOT_F0;
          end else if (received_data == 8'hE1) begin
            state_d   = SKIP_E1;
            skipCnt_d = 3'd7;
          end else if (received_data == 8'hAA || received_data == 8'hFA ||
                       received_data == 8'hFE || received_data == 8'hEE ||
                       received_data == 8'h00 || received_data == 8'hFF) begin
            state_d = IDLE;
          end else begin
            emitMake = 1'b1;
          end
        end
        GOT_E0: begin
          state_d = IDLE;
          if (received_data == 8'hF0) begin
            state_d = GOT_E0F0;
          end else if (received_data == 8'h12 || received_data == 8'h59) begin
            state_d = IDLE;
          end else if (received_data == 8'hE0 || received_data == 8'hE1 ||
                       received_data >= 8'hAA) begin
            errPulse = 1'b1;
          end else begin
            emitMake = 1'b1;
            emitExt  = 1'b1;
          end
        end
        GOT_F0: begin
          state_d = IDLE;
          if (received_data == 8'hE0 || received_data == 8'hE1 ||
              received_data == 8'hF0) begin
            errPulse = 1'b1;
          end else begin
            emitBreak = 1'b1;
          end
        end
        GOT_E0F0: begin
          state_d = IDLE;
          if (received_data == 8'h12 || received_data == 8'h59) begin
            state_d = IDLE;
          end else if (received_data == 8'hE0 || received_data == 8'hE1 ||
                       received_data == 8'hF0) begin
            errPulse = 1'b1;
          end else begin
            emitBreak = 1'b1;
            emitExt   = 1'b1;
          end
        end
        SKIP_E1: begin
          skipCnt_d = skipCnt_q - 3'd1;
          if (skipCnt_q <= 3'd1) begin
            skipCnt_d = 3'd0;
            state_d   = IDLE;
          end
        end
        default: begin
          state_d   = IDLE;
          skipCnt_d = 3'd0;
        end
      endcase
    end else if (state_q != IDLE) begin
      if (idleCnt_q == TIMEOUT_LAST) begin
        state_d   = IDLE;
        skipCnt_d = 3'd0;
        idleCnt_d = '0;
        errPulse  = 1'b1;
      end else begin
        idleCnt_d = idleCnt_q + 22'd1;
      end
    end else begin
      idleCnt_d = '0;
    end
  end

  // Event outputs: loads the key fields and updates held flags when an
  // event is emitted; the typematic record, when built in, can veto makes.
  always_comb begin
    keyValid_d = 1'b0;
    keyCode_d  = keyCode_q;
    keyExt_d   = keyExt_q;
    keyRel_d   = keyRel_q;
    held_d     = held_q;
    protoErr_d = errPulse;
    suppress   = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
    recValid_d = recValid_q;
    recExt_d   = recExt_q;
    recCode_d  = recCode_q;
    recMatch   = recValid_q && (recExt_q == emitExt) && (recCode_q == received_data);
    if (emitMake) begin
      if (recMatch) begin
        suppress = 1'b1;
      end else begin
        recValid_d = 1'b1;
        recExt_d   = emitExt;
        recCode_d  = received_data;
      end
    end else if (emitBreak && recMatch) begin
      recValid_d = 1'b0;
    end
`endif
    if ((emitMake && !suppress) || emitBreak) begin
      keyValid_d = 1'b1;
      keyCode_d  = received_data;
      keyExt_d   = emitExt;
      keyRel_d   = emitBreak;
      if (emitMake) begin
        held_d = held_q | heldMask(emitExt, received_data);
      end else begin
        held_d = held_q & ~heldMask(emitExt, received_data);
      end
    end
  end

  // State and output registers; reset drops any pending prefix.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= IDLE;
      skipCnt_q  <= 3'd0;
      idleCnt_q  <= '0;
      keyValid_q <= 1'b0;
      keyCode_q  <= 8'h00;
      keyExt_q   <= 1'b0;
      keyRel_q   <= 1'b0;
      held_q     <= 5'b00000;
      protoErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skipCnt_q  <= skipCnt_d;
      idleCnt_q  <= idleCnt_d;
      keyValid_q <= keyValid_d;
      keyCode_q  <= keyCode_d;
      keyExt_q   <= keyExt_d;
      keyRel_q   <= keyRel_d;
      held_q     <= held_d;
      protoErr_q <= protoErr_d;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  // Typematic record of the last emitted make.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      recValid_q <= 1'b0;
      recExt_q   <= 1'b0;
      recCode_q  <= 8'h00;
    end else begin
      recValid_q <= recValid_d;
      recExt_q   <= recExt_d;
      recCode_q  <= recCode_d;
    end
  end
`endif

  assign key_valid    = keyValid_q;
  assign key_code     = keyCode_q;
  assign key_extended = keyExt_q;
  assign key_released = keyRel_q;
  assign key_held     = held_q;
  assign protocol_err = protoErr_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Testbench for ps2_scancode_decoder: table of single bytes with expected
// post-byte outputs, plus hand sequences for timeout, typematic, back-to-back
// strobes and mid-sequence reset.

module tb_ps2_scancode_decoder;

  logic       CLOCK_50;
  logic       reset;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_released;
  logic [4:0] key_held;
  logic       protocol_err;

  int total = 0;
  int bad = 0;
  int validCount = 0;
  int errCount = 0;
  int overlapCount = 0;

  typedef struct {
    logic [7:0] data;
    logic       expValid;
    logic       expErr;
    logic [7:0] expCode;
    logic       expExt;
    logic       expRel;
    logic [4:0] expHeld;
  } vec_t;

  vec_t vecs[$];

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(100)) dut (
    .CLOCK_50        (CLOCK_50),
    .reset           (reset),
    .received_data   (received_data),
    .received_data_en(received_data_en),
    .key_valid       (key_valid),
    .key_code        (key_code),
    .key_extended    (key_extended),
    .key_released    (key_released),
    .key_held        (key_held),
    .protocol_err    (protocol_err)
  );

  // 50 MHz clock
  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  // Counts event and error pulses and any cycle where both are high
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (key_valid) validCount++;
      if (protocol_err) errCount++;
      if (key_valid && protocol_err) overlapCount++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One strobe; returns on the negedge where the result is visible
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge CLOCK_50);
    received_data    = b;
    received_data_en = 1'b1;
    @(negedge CLOCK_50);
    received_data_en = 1'b0;
  endtask

  task automatic addVec(input logic [7:0] d, input logic v, input logic e,
                        input logic [7:0] c, input logic x, input logic r,
                        input logic [4:0] h);
    vec_t t;
    t.data = d; t.expValid = v; t.expErr = e; t.expCode = c;
    t.expExt = x; t.expRel = r; t.expHeld = h;
    vecs.push_back(t);
  endtask

  initial begin
    int v0, e0;
    // data  valid err code  ext rel held
    addVec(8'h1D, 1, 0, 8'h1D, 0, 0, 5'b00000);
    addVec(8'hE0, 0, 0, 8'h00, 0, 0, 5'b00000);
    addVec(8'h75, 1, 0, 8'h75, 1, 0, 5'b00001);
    addVec(8'hE0, 0, 0, 8'h00, 0, 0, 5'b00001);
    addVec(8'hF0, 0, 0, 8'h00, 0, 0, 5'b00001);
    addVec(8'h75, 1, 0, 8'h75, 1, 1, 5'b00000);
    addVec(8'hE1, 0, 0, 8'h00, 0, 0, 5'b00000);
    addVec(8'h14, 0, 0, 8'h00, 0, 0, 5'b00000);
    addVec(8'h77, 0, 0, 8'h00, 0, 0, 5'b00000);
    addVec(8'hE1, 0, 0, 8'h00, 0, 0, 5'b00000);
    addVec(8'hF0, 0, 0, 8'h00, 0, 0, 5'b00000);
    addVec(8'h14, 0, 0, 8'h00, 0, 0, 5'b00000);
    addVec(8'hF0, 0, 0, 8'h00, 0, 0, 5'b00000);
    addVec(8'h77, 0, 0, 8'h00, 0, 0, 5'b00000);
    addVec(8'h29, 1, 0, 8'h29, 0, 0, 5'b10000);
    addVec(8'hE0, 0, 0, 8'h00, 0, 0, 5'b10000);
    addVec(8'h12, 0, 0, 8'h00, 0, 0, 5'b10000);
    addVec(8'hE0, 0, 0, 8'h00, 0, 0, 5'b10000);
    addVec(8'hE0, 0, 1, 8'h00, 0, 0, 5'b10000);
    addVec(8'hF0, 0, 0, 8'h00, 0, 0, 5'b10000);
    addVec(8'hE1, 0, 1, 8'h00, 0, 0, 5'b10000);
    addVec(8'hAA, 0, 0, 8'h00, 0, 0, 5'b10000);
    addVec(8'hE0, 0, 0, 8'h00, 0, 0, 5'b10000);
    addVec(8'h6B, 1, 0, 8'h6B, 1, 0, 5'b10100);
    addVec(8'hE0, 0, 0, 8'h00, 0, 0, 5'b10100);
    addVec(8'hF0, 0, 0, 8'h00, 0, 0, 5'b10100);
    addVec(8'h59, 0, 0, 8'h00, 0, 0, 5'b10100);
    addVec(8'hF0, 0, 0, 8'h00, 0, 0, 5'b10100);
    addVec(8'h29, 1, 0, 8'h29, 0, 1, 5'b00100);
    addVec(8'hE0, 0, 0, 8'h00, 0, 0, 5'b00100);
    addVec(8'h74, 1, 0, 8'h74, 1, 0, 5'b01100);
    addVec(8'hE0, 0, 0, 8'h00, 0, 0, 5'b01100);
    addVec(8'hF0, 0, 0, 8'h00, 0, 0, 5'b01100);
    addVec(8'h6B, 1, 0, 8'h6B, 1, 1, 5'b01000);
    addVec(8'hE0, 0, 0, 8'h00, 0, 0, 5'b01000);
    addVec(8'hFF, 0, 1, 8'h00, 0, 0, 5'b01000);
    addVec(8'h5A, 1, 0, 8'h5A, 0, 0, 5'b01000);
    addVec(8'hE0, 0, 0, 8'h00, 0, 0, 5'b01000);
    addVec(8'hF0, 0, 0, 8'h00, 0, 0, 5'b01000);
    addVec(8'hF0, 0, 1, 8'h00, 0, 0, 5'b01000);
    addVec(8'hF0, 0, 0, 8'h00, 0, 0, 5'b01000);
    addVec(8'h5A, 1, 0, 8'h5A, 0, 1, 5'b01000);

    reset            = 1'b1;
    received_data    = 8'h00;
    received_data_en = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    checkOutput("reset_outputs",
                {15'd0, key_valid, key_code, key_extended, key_released, key_held, protocol_err}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].data);
      checkOutput($sformatf("v%0d_valid", i), 32'(key_valid), 32'(vecs[i].expValid));
      checkOutput($sformatf("v%0d_err", i), 32'(protocol_err), 32'(vecs[i].expErr));
      checkOutput($sformatf("v%0d_held", i), 32'(key_held), 32'(vecs[i].expHeld));
      if (vecs[i].expValid) begin
        checkOutput($sformatf("v%0d_code", i), 32'(key_code), 32'(vecs[i].expCode));
        checkOutput($sformatf("v%0d_ext", i), 32'(key_extended), 32'(vecs[i].expExt));
        checkOutput($sformatf("v%0d_rel", i), 32'(key_released), 32'(vecs[i].expRel));
      end
    end

    // Typematic repeats of space then its break
    #1;
    v0 = validCount;
    e0 = errCount;
    applyStimulus(8'h29);
    applyStimulus(8'h29);
    applyStimulus(8'h29);
    applyStimulus(8'hF0);
    applyStimulus(8'h29);
    #1;
`ifdef PS2_TYPEMATIC_FILTER_EN
    checkOutput("typematic_events", 32'(validCount - v0), 32'd2);
`else
    checkOutput("typematic_events", 32'(validCount - v0), 32'd4);
`endif
    checkOutput("typematic_errs", 32'(errCount - e0), 32'd0);
    checkOutput("typematic_held", 32'(key_held), 32'(5'b01000));

    // Back-to-back strobes: E0 72 then E0 F0 72
    @(negedge CLOCK_50);
    received_data = 8'hE0; received_data_en = 1'b1;
    @(negedge CLOCK_50);
    received_data = 8'h72;
    checkOutput("b2b_no_early_valid", 32'(key_valid), 32'd0);
    @(negedge CLOCK_50);
    received_data = 8'hE0;
    checkOutput("b2b_make_valid", 32'(key_valid), 32'd1);
    checkOutput("b2b_make_code", 32'(key_code), 32'h72);
    checkOutput("b2b_make_held", 32'(key_held), 32'(5'b01010));
    @(negedge CLOCK_50);
    received_data = 8'hF0;
    checkOutput("b2b_gap_valid", 32'(key_valid), 32'd0);
    @(negedge CLOCK_50);
    received_data = 8'h72;
    @(negedge CLOCK_50);
    received_data_en = 1'b0;
    checkOutput("b2b_break_valid", 32'(key_valid), 32'd1);
    checkOutput("b2b_break_rel", 32'(key_released), 32'd1);
    checkOutput("b2b_break_held", 32'(key_held), 32'(5'b01000));

    // Timeout: E0 then silence, then 1C decoded from IDLE
    #1;
    v0 = validCount;
    e0 = errCount;
    applyStimulus(8'hE0);
    repeat (105) @(negedge CLOCK_50);
    #1;
    checkOutput("timeout_err_pulses", 32'(errCount - e0), 32'd1);
    checkOutput("timeout_no_event", 32'(validCount - v0), 32'd0);
    applyStimulus(8'h1C);
    checkOutput("timeout_next_valid", 32'(key_valid), 32'd1);
    checkOutput("timeout_next_code", 32'(key_code), 32'h1C);
    checkOutput("timeout_next_ext", 32'(key_extended), 32'd0);

    // Reset mid-sequence
    applyStimulus(8'hE0);
    reset = 1'b1;
    @(negedge CLOCK_50);
    checkOutput("midreset_outputs",
                {15'd0, key_valid, key_code, key_extended, key_released, key_held, protocol_err}, 32'd0);
    reset = 1'b0;
    applyStimulus(8'h75);
    checkOutput("midreset_valid", 32'(key_valid), 32'd1);
    checkOutput("midreset_code", 32'(key_code), 32'h75);
    checkOutput("midreset_ext", 32'(key_extended), 32'd0);
    checkOutput("midreset_held", 32'(key_held), 32'd0);

    repeat (2) @(negedge CLOCK_50);
    #1;
    checkOutput("valid_err_overlap", 32'(overlapCount), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes the raw byte stream from the PS/2 controller (`received_data` / `received_data_en`) and turns PS/2 Set-2 scan-code sequences into single key events. Each event carries a code, an extended flag and a make/break flag. It also keeps held-state flags for the MiniPaint cursor and draw keys. It sits directly downstream of the keyboard capture stage and upstream of the paint control FSM.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 2500000: idle cycles (50 ms at 50 MHz) after which a partial prefix sequence is abandoned.

Ports:
- `CLOCK_50`, input, 1: system clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high. Overrides every other input.
- `received_data`, input, 8: byte from the PS/2 controller.
- `received_data_en`, input, 1: one-cycle strobe marking `received_data` as valid.
- `key_valid`, output, 1: one-cycle pulse. A decoded event is present on the `key_*` outputs.
- `key_code`, output, 8: final scan-code byte of the event. Held stable until the next event.
- `key_extended`, output, 1: the sequence contained an E0 prefix.
- `key_released`, output, 1: the sequence contained an F0 prefix (break).
- `key_held`, output, 5: held flags {space 29, right E0 74, left E0 6B, down E0 72, up E0 75}, bit 0 = up.
- `protocol_err`, output, 1: one-cycle pulse on a malformed sequence or a timeout.

## Operation
- States: IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP_E1. Bytes are processed only on cycles with `received_data_en` = 1.
- IDLE:
  - E0 → GOT_E0.
  - F0 → GOT_F0.
  - E1 → SKIP_E1 with skip count 7.
  - AA, FA, FE, EE, 00, FF → ignored, stay in IDLE, no error.
  - Any other byte → emit a make event with ext = 0.
- GOT_E0:
  - F0 → GOT_E0F0.
  - 12 or 59 (fake shift) → discard, return to IDLE.
  - E0, E1 or AA–FF → `protocol_err`, return to IDLE.
  - Other → emit a make event with ext = 1, return to IDLE.
- GOT_F0:
  - E0, E1, F0 → `protocol_err`, return to IDLE.
  - Other → emit a break event with ext = 0, return to IDLE.
- GOT_E0F0:
  - 12 or 59 → discard, return to IDLE.
  - E0, E1, F0 → `protocol_err`, return to IDLE.
  - Other → emit a break event with ext = 1, return to IDLE.
- SKIP_E1: each byte decrements the skip count. At 0, return to IDLE. No events are emitted, so Pause is swallowed entirely.
- Emitting an event loads `key_code`, `key_extended` and `key_released`, and pulses `key_valid`.
- The `key_held` bit for a matching {ext, code} is set on make and cleared on break, in the same cycle that `key_valid` rises. Non-matching codes leave `key_held` unchanged.
- Timeout:
  - A 22-bit idle counter clears on every byte and increments while the state ≠ IDLE.
  - When it reaches `TIMEOUT_CYCLES - 1` with no byte that cycle: return to IDLE, pulse `protocol_err`, emit no event.
  - If a byte and expiry coincide, the byte wins and is decoded in the current state.

## Timing
- Latency: `key_valid` rises exactly one cycle after the `received_data_en` strobe carrying the final byte.
- Throughput: one byte per cycle is accepted. Back-to-back strobes are legal.
- `key_valid` and `protocol_err` are never high in the same cycle and never longer than one cycle.
- Reset values:
  - All outputs 0.
  - State IDLE, idle counter 0, skip count 0.
  - Typematic record invalid.
- Reset mid-sequence: any pending prefix is discarded. The next byte after reset is decoded from IDLE.

## Configuration
- `PS2_TYPEMATIC_FILTER_EN` defined:
  - Holds a record {ext, code, valid} of the last emitted make.
  - A make matching a valid record is suppressed: no `key_valid`, no error.
  - A break matching the record invalidates it.
  - Any different make overwrites the record.
- Not defined: every make is emitted, including typematic repeats. The record logic is absent.

## Test plan
- Byte 1D → one cycle later `key_valid` = 1, `key_code` = 1D, ext = 0, rel = 0. `key_held` stays 00000.
- Bytes E0 75, then E0 F0 75:
  - First event: code 75, ext = 1, rel = 0, `key_held` = 00001.
  - Second event: code 75, ext = 1, rel = 1, `key_held` = 00000.
- Bytes E1 14 77 E1 F0 14 F0 77, then 29:
  - No `key_valid` and no `protocol_err` during the Pause bytes.
  - Then one event with code 29, `key_held` = 10000.
- With `TIMEOUT_CYCLES` = 100: E0, wait 100 idle cycles, then 1C.
  - `protocol_err` pulses once.
  - Then a 1C event with ext = 0.
- Bytes 29 29 29 F0 29:
  - With `PS2_TYPEMATIC_FILTER_EN`: exactly 2 events (make, break).
  - Without it: 4 events (3 makes, 1 break).
- E0, then `reset` for 1 cycle, then 75 → event with code 75, ext = 0. All outputs were 0 during the reset cycle.
